// File: rtl/kmeans_pkg.sv
// kmeans_pkg
//   Shared definitions for the k-means phase controller: 3-bit state
//   encoding, point-RAM owner codes, default run limits and small decode
//   helpers used by the sequencer.
package kmeans_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ASSIGN = 3'd1,
    ST_GAP_A  = 3'd2,
    ST_SUM    = 3'd3,
    ST_GAP_S  = 3'd4,
    ST_UPDATE = 3'd5,
    ST_CHECK  = 3'd6,
    ST_FINISH = 3'd7
  } state_t;

  // Point-RAM owner codes; code 3 is reserved and never produced.
  localparam logic [1:0] MEM_NONE   = 2'd0;
  localparam logic [1:0] MEM_ASSIGN = 2'd1;
  localparam logic [1:0] MEM_SUM    = 2'd2;

  localparam int DEF_MAX_ITER    = 10;
  localparam int DEF_TIMEOUT_CYC = 4096;

  // RAM owner for a given state. Only ASSIGN and SUM touch the point RAM.
  function automatic logic [1:0] mem_sel_for(input state_t s);
    logic [1:0] sel;
    sel = MEM_NONE;
    if (s == ST_ASSIGN) sel = MEM_ASSIGN;
    else if (s == ST_SUM) sel = MEM_SUM;
    return sel;
  endfunction

  // States in which an external engine is working and may hang.
  function automatic logic phase_active(input state_t s);
    return (s == ST_ASSIGN) || (s == ST_SUM) || (s == ST_UPDATE);
  endfunction

endpackage

// File: rtl/phase_watchdog.sv
// phase_watchdog
//   Cycle counter that measures how long the current phase has been active.
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset
//     clr         restart the count (phase change)
//     en          count this cycle (a phase is active)
//     expire      high during the TIMEOUT_CYC-th active cycle of a phase
module phase_watchdog #(
  parameter int TMO_W       = 13,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [TMO_W-1:0] LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr || !en) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // count_reg is 0 in the first active cycle, so LAST marks the
  // TIMEOUT_CYC-th cycle spent in the phase.
  assign expire = en && (count_reg == LAST);

endmodule

// File: rtl/kmeans_sequencer.sv
// kmeans_sequencer
//   Phase controller for the k-means engine. Runs assign -> sum -> update
//   per iteration, owns the point-RAM select, counts iterations and ends a
//   run on convergence, on the iteration limit, on a phase timeout or abort.
//   Ports:
//     clk, rst_n         clock, asynchronous active-low reset
//     start, abort       run control pulses
//     assign_en/_done    assign_cluster handshake
//     sum_en/_done       get_sum handshake
//     update_en/_done    division bank handshake, centroid_changed with done
//     mem_sel            point-RAM owner (0 none, 1 assign, 2 sum)
//     busy, done         run in progress, end-of-run pulse
//     converged, error   sticky run result flags
//     iter_count         completed iterations of current/last run
module kmeans_sequencer
  import kmeans_pkg::*;
#(
  parameter int MAX_ITER    = DEF_MAX_ITER,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int ITER_W      = 8,
  parameter int TMO_W       = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              assign_en,
  input  logic              assign_done,
  output logic              sum_en,
  input  logic              sum_done,
  output logic              update_en,
  input  logic              update_done,
  input  logic              centroid_changed,
  output logic [1:0]        mem_sel,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic              error,
  output logic [ITER_W-1:0] iter_count
);

  localparam logic [ITER_W-1:0] ITER_SAT   = '1;
  localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);

  state_t            state_reg;
  state_t            state_next;
  logic              chg_q;
  logic              tmo_hit;
  logic              wd_clr;
  logic              wd_en;
  logic              wd_expire;
  logic [ITER_W-1:0] iter_inc;

  assign iter_inc = (iter_count == ITER_SAT) ? iter_count : iter_count + 1'b1;
  assign wd_clr   = (state_next != state_reg);
  assign wd_en    = phase_active(state_reg);

  phase_watchdog #(
    .TMO_W       (TMO_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (wd_clr),
    .en     (wd_en),
    .expire (wd_expire)
  );

  // Each done input is only looked at in its own state, so a done level left
  // over from an earlier phase cannot advance a later one. A done arriving in
  // the same cycle as the timeout counts as completion.
  always_comb begin
    state_next = state_reg;
    tmo_hit    = 1'b0;
    case (state_reg)
      ST_IDLE:   if (start) state_next = ST_ASSIGN;
      ST_ASSIGN: begin
        if (assign_done) state_next = ST_GAP_A;
        else if (wd_expire) begin
          state_next = ST_FINISH;
          tmo_hit    = 1'b1;
        end
      end
      ST_GAP_A:  state_next = ST_SUM;
      ST_SUM: begin
        if (sum_done) state_next = ST_GAP_S;
        else if (wd_expire) begin
          state_next = ST_FINISH;
          tmo_hit    = 1'b1;
        end
      end
      ST_GAP_S:  state_next = ST_UPDATE;
      ST_UPDATE: begin
        if (update_done) state_next = ST_CHECK;
        else if (wd_expire) begin
          state_next = ST_FINISH;
          tmo_hit    = 1'b1;
        end
      end
      ST_CHECK: begin
        if (!chg_q || (iter_inc == ITER_LIMIT)) state_next = ST_FINISH;
        else state_next = ST_ASSIGN;
      end
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
    // Abort overrides every other event, including a same-cycle timeout.
    if (abort && (state_reg != ST_IDLE)) begin
      state_next = ST_IDLE;
      tmo_hit    = 1'b0;
    end
  end

  // Outputs are registered from state_next so they line up with the state
  // register and never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      assign_en  <= 1'b0;
      sum_en     <= 1'b0;
      update_en  <= 1'b0;
      mem_sel    <= MEM_NONE;
      busy       <= 1'b0;
      done       <= 1'b0;
      converged  <= 1'b0;
      error      <= 1'b0;
      iter_count <= '0;
      chg_q      <= 1'b0;
    end else begin
      state_reg <= state_next;
      assign_en <= (state_next == ST_ASSIGN);
      sum_en    <= (state_next == ST_SUM);
      update_en <= (state_next == ST_UPDATE);
      mem_sel   <= mem_sel_for(state_next);
      busy      <= (state_next != ST_IDLE) && (state_next != ST_FINISH);
      done      <= (state_next == ST_FINISH);

      if ((state_reg == ST_IDLE) && start) begin
        iter_count <= '0;
        converged  <= 1'b0;
        error      <= 1'b0;
      end
      if ((state_reg == ST_UPDATE) && update_done && !abort) begin
        chg_q <= centroid_changed;
      end
      if ((state_reg == ST_CHECK) && !abort) begin
        iter_count <= iter_inc;
        if (!chg_q) converged <= 1'b1;
      end
      if (tmo_hit) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_kmeans_sequencer.sv
// tb_kmeans_sequencer
//   Self-checking bench: a behavioural responder plays the three engines
//   (done 5 cycles after each enable), run results are queued when a run is
//   started and compared when the done pulse appears.
module tb_kmeans_sequencer;

  localparam int MAX_ITER    = 4;
  localparam int TIMEOUT_CYC = 16;
  localparam int ITER_W      = 8;
  localparam int TMO_W       = 13;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic assign_done = 1'b0;
  logic sum_done = 1'b0;
  logic update_done = 1'b0;
  logic centroid_changed = 1'b0;
  logic assign_en, sum_en, update_en, busy, done, converged, error;
  logic [1:0] mem_sel;
  logic [ITER_W-1:0] iter_count;

  always #5 clk = ~clk;

  kmeans_sequencer #(
    .MAX_ITER    (MAX_ITER),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .ITER_W      (ITER_W),
    .TMO_W       (TMO_W)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .abort            (abort),
    .assign_en        (assign_en),
    .assign_done      (assign_done),
    .sum_en           (sum_en),
    .sum_done         (sum_done),
    .update_en        (update_en),
    .update_done      (update_done),
    .centroid_changed (centroid_changed),
    .mem_sel          (mem_sel),
    .busy             (busy),
    .done             (done),
    .converged        (converged),
    .error            (error),
    .iter_count       (iter_count)
  );

  typedef struct packed {
    logic [7:0] iter;
    logic       conv;
    logic       err;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- engine responder ----------------
  int a_cnt = 0, s_cnt = 0, u_cnt = 0;
  bit never_sum = 1'b0;
  bit stray = 1'b0;
  bit chg_pat[$];

  always @(negedge clk) begin
    a_cnt = assign_en ? a_cnt + 1 : 0;
    s_cnt = sum_en ? s_cnt + 1 : 0;
    u_cnt = update_en ? u_cnt + 1 : 0;
    // In stray mode assign_done stays high through GAP_A and SUM.
    assign_done = (a_cnt == 5) || (stray && assign_done && !update_en);
    sum_done = (s_cnt == 5) && !never_sum;
    if (u_cnt == 5) begin
      update_done = 1'b1;
      centroid_changed = (chg_pat.size() > 0) ? chg_pat.pop_front() : 1'b1;
    end else begin
      update_done = 1'b0;
      centroid_changed = 1'b0;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int cyc = 0, done_cnt = 0, assign_rises = 0, update_rises = 0;
  int last_upd_fall = 0, last_done_lat = 0, sum_run = 0, last_sum_len = 0, mem_viol = 0;
  logic prev_assign_en = 1'b0, prev_update_en = 1'b0, prev_done = 1'b0;
  logic [1:0] prev_mem_sel = 2'd0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (assign_en && !prev_assign_en) assign_rises++;
    if (update_en && !prev_update_en) update_rises++;
    if (!update_en && prev_update_en) last_upd_fall = cyc;
    if (sum_en) sum_run++;
    else begin
      if (sum_run != 0) last_sum_len = sum_run;
      sum_run = 0;
    end
    if ((mem_sel == 2'd3) || (mem_sel == 2'd1 && prev_mem_sel == 2'd2) ||
        (mem_sel == 2'd2 && prev_mem_sel == 2'd1)) mem_viol++;
    if (done && !prev_done) begin
      done_cnt++;
      last_done_lat = cyc - last_upd_fall;
      check_val("sb_pending", 32'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        $display("DONE iter_count=%0d converged=%0b error=%0b (exp %0d/%0b/%0b)",
                 iter_count, converged, error, e.iter, e.conv, e.err);
        check_val("done_iter", 32'(iter_count), 32'(e.iter));
        check_val("done_conv", 32'(converged), 32'(e.conv));
        check_val("done_err", 32'(error), 32'(e.err));
        check_val("done_busy", 32'(busy), 0);
      end
    end
    prev_assign_en = assign_en;
    prev_update_en = update_en;
    prev_done = done;
    prev_mem_sel = mem_sel;
  end

  // ---------------- helpers ----------------
  task automatic do_start(input string tag);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    $display("START %s", tag);
    check_val({tag, "_first_en"}, 32'({assign_en, mem_sel, busy, converged, error, iter_count}),
              32'({1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 8'd0}));
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0 = done_cnt;
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt != d0) seen = 1'b1;
    end
    check_val({tag, "_done_seen"}, 32'(seen), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end

  // ---------------- test sequence ----------------
  initial begin
    int d0, r0, u0;
    bit found;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_outputs",
              32'({assign_en, sum_en, update_en, mem_sel, busy, done, converged, error, iter_count}), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Normal convergence on the third iteration.
    chg_pat = '{1'b1, 1'b1, 1'b0};
    sb_q.push_back('{iter: 8'd3, conv: 1'b1, err: 1'b0});
    d0 = done_cnt; r0 = assign_rises;
    do_start("conv");
    wait_done("conv", 400);
    check_val("conv_assign_rises", 32'(assign_rises - r0), 3);
    check_val("conv_done_lat", 32'(last_done_lat), 1);
    repeat (3) @(negedge clk);
    #1;
    check_val("conv_done_cnt", 32'(done_cnt - d0), 1);
    check_val("conv_idle", 32'({busy, done, assign_en}), 0);

    // Iteration limit.
    chg_pat.delete();
    sb_q.push_back('{iter: 8'd4, conv: 1'b0, err: 1'b0});
    d0 = done_cnt; r0 = assign_rises;
    do_start("limit");
    wait_done("limit", 400);
    check_val("limit_assign_rises", 32'(assign_rises - r0), 4);
    repeat (3) @(negedge clk);
    #1;
    check_val("limit_done_cnt", 32'(done_cnt - d0), 1);

    // Watchdog: sum never completes.
    never_sum = 1'b1;
    sb_q.push_back('{iter: 8'd0, conv: 1'b0, err: 1'b1});
    do_start("wdog");
    wait_done("wdog", 200);
    check_val("wdog_sum_len", 32'(last_sum_len), 16);
    check_val("wdog_en_off", 32'({assign_en, sum_en, update_en, mem_sel}), 0);
    never_sum = 1'b0;
    repeat (3) @(negedge clk);

    // Abort during UPDATE of iteration 2.
    chg_pat.delete();
    d0 = done_cnt; u0 = update_rises;
    do_start("abort");
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      #1;
      if ((update_rises - u0) >= 2) found = 1'b1;
    end
    check_val("abort_reach_update2", 32'(found), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    check_val("abort_idle", 32'({assign_en, sum_en, update_en, mem_sel, busy, done}), 0);
    check_val("abort_iter", 32'(iter_count), 1);
    repeat (10) @(negedge clk);
    #1;
    check_val("abort_no_done", 32'(done_cnt - d0), 0);
    // Follow-up run: start clears iter_count (checked in do_start).
    chg_pat = '{1'b0};
    sb_q.push_back('{iter: 8'd1, conv: 1'b1, err: 1'b0});
    do_start("abort_restart");
    wait_done("abort_restart", 200);
    repeat (3) @(negedge clk);

    // Stray assign_done held into SUM, plus start pulse during SUM.
    stray = 1'b1;
    chg_pat = '{1'b1, 1'b0};
    sb_q.push_back('{iter: 8'd2, conv: 1'b1, err: 1'b0});
    d0 = done_cnt;
    do_start("stray");
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      #1;
      if (sum_en) found = 1'b1;
    end
    check_val("stray_reach_sum", 32'(found), 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check_val("stray_start_ignored", 32'({sum_en, busy, mem_sel}), 32'({1'b1, 1'b1, 2'd2}));
    wait_done("stray", 400);
    check_val("stray_sum_len", 32'(last_sum_len), 5);
    stray = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    check_val("stray_one_run", 32'({busy, 8'(done_cnt - d0)}), 32'({1'b0, 8'd1}));

    // Asynchronous reset in the middle of ASSIGN.
    do_start("async_rst");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("async_rst_outputs",
              32'({assign_en, sum_en, update_en, mem_sel, busy, done, converged, error, iter_count}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_val("post_rst_idle", 32'({assign_en, mem_sel, busy}), 0);

    check_val("mem_sel_turnaround", 32'(mem_viol), 0);
    check_val("sb_empty", 32'(sb_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
